// File: rtl/sys_defs.sv
// Shared definitions for the issue scheduler: FU classes and default sizing.
package sys_defs;

  typedef enum logic [1:0] {
    FU_ALU  = 2'd0,
    FU_MULT = 2'd1,
    FU_MEM  = 2'd2
  } fu_type_e;

  localparam int SYS_N_RS     = 8;
  localparam int SYS_MULT_LAT = 4;

  function automatic logic fu_match(input fu_type_e fu, input fu_type_e cls);
    return (fu == cls);
  endfunction

endpackage

// File: rtl/issue_scheduler_age_select.sv
// Picks the oldest eligible slot: a slot wins when no eligible slot is older than it.
module age_select #(
  parameter int N     = 8,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]        eligible,
  input  logic [N-1:0][N-1:0] older,
  output logic                grant_valid,
  output logic [IDX_W-1:0]    grant_idx
);

  logic [N-1:0] blocked;
  logic [N-1:0] win;

  // A slot is blocked by any eligible slot that is older than it.
  always_comb begin
    blocked = '0;
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        blocked[i] = blocked[i] | (older[j][i] & eligible[j]);
      end
    end
  end

  assign win         = eligible & ~blocked;
  assign grant_valid = |win;

  // Ages are a strict order over valid slots, so win is at most one-hot.
  always_comb begin
    grant_idx = '0;
    for (int i = 0; i < N; i++) begin
      grant_idx = grant_idx | (IDX_W'(i) & {IDX_W{win[i]}});
    end
  end

endmodule

// File: rtl/issue_scheduler.sv
// RS issue-select: tracks slot validity, FU class and age; grants the oldest ready
// slot per FU each cycle and sequences the unpipelined multiplier.
module issue_scheduler import sys_defs::*; #(
  parameter int N_RS     = SYS_N_RS,
  parameter int IDX_W    = $clog2(N_RS),
  parameter int MULT_LAT = SYS_MULT_LAT
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              alloc_valid,
  input  logic [IDX_W-1:0]  alloc_idx,
  input  fu_type_e          alloc_fu,
  input  logic [N_RS-1:0]   entry_ready,
  input  logic              mem_stall,
  input  logic              flush,
  output logic              alu_issue_valid,
  output logic [IDX_W-1:0]  alu_issue_idx,
  output logic              mult_issue_valid,
  output logic [IDX_W-1:0]  mult_issue_idx,
  output logic              mem_issue_valid,
  output logic [IDX_W-1:0]  mem_issue_idx,
  output logic [N_RS-1:0]   issue_clear,
  output logic              mult_busy
);

  localparam int CNT_W = $clog2(MULT_LAT + 1);

  logic [N_RS-1:0]            valid_q, valid_d;
  fu_type_e [N_RS-1:0]        fu_q, fu_d;
  logic [N_RS-1:0][N_RS-1:0]  older_q, older_d;
  logic [CNT_W-1:0]           mult_cnt_q, mult_cnt_d;

  logic                       alu_valid_q, alu_valid_d;
  logic                       mult_valid_q, mult_valid_d;
  logic                       mem_valid_q, mem_valid_d;
  logic [IDX_W-1:0]           alu_idx_q, alu_idx_d;
  logic [IDX_W-1:0]           mult_idx_q, mult_idx_d;
  logic [IDX_W-1:0]           mem_idx_q, mem_idx_d;

  logic [N_RS-1:0]            elig_alu, elig_mult, elig_mem;
  logic                       sel_alu_valid, sel_mult_valid, sel_mem_valid;
  logic [IDX_W-1:0]           sel_alu_idx, sel_mult_idx, sel_mem_idx;
  logic                       gnt_alu, gnt_mult, gnt_mem;
  logic [N_RS-1:0]            grant_mask, alloc_mask;
  logic                       do_alloc;

  function automatic logic [N_RS-1:0] to_onehot(input logic [IDX_W-1:0] idx, input logic en);
    logic [N_RS-1:0] oh;
    oh      = '0;
    oh[idx] = en;
    return oh;
  endfunction

  // Per-class eligibility from the tracked state and the RS ready bits.
  always_comb begin
    elig_alu  = '0;
    elig_mult = '0;
    elig_mem  = '0;
    for (int i = 0; i < N_RS; i++) begin
      elig_alu[i]  = valid_q[i] & entry_ready[i] & fu_match(fu_q[i], FU_ALU);
      elig_mult[i] = valid_q[i] & entry_ready[i] & fu_match(fu_q[i], FU_MULT);
      elig_mem[i]  = valid_q[i] & entry_ready[i] & fu_match(fu_q[i], FU_MEM);
    end
  end

  age_select #(.N(N_RS), .IDX_W(IDX_W)) u_sel_alu (
    .eligible(elig_alu), .older(older_q), .grant_valid(sel_alu_valid), .grant_idx(sel_alu_idx)
  );
  age_select #(.N(N_RS), .IDX_W(IDX_W)) u_sel_mult (
    .eligible(elig_mult), .older(older_q), .grant_valid(sel_mult_valid), .grant_idx(sel_mult_idx)
  );
  age_select #(.N(N_RS), .IDX_W(IDX_W)) u_sel_mem (
    .eligible(elig_mem), .older(older_q), .grant_valid(sel_mem_valid), .grant_idx(sel_mem_idx)
  );

  // Counter at 1 means the unit frees up at the same edge the new grant registers.
  assign gnt_alu  = sel_alu_valid;
  assign gnt_mult = sel_mult_valid & (mult_cnt_q <= CNT_W'(1));
  assign gnt_mem  = sel_mem_valid & ~mem_stall;

  assign grant_mask = to_onehot(sel_alu_idx, gnt_alu)
                    | to_onehot(sel_mult_idx, gnt_mult)
                    | to_onehot(sel_mem_idx, gnt_mem);
  assign do_alloc   = alloc_valid & ~flush;
  assign alloc_mask = to_onehot(alloc_idx, do_alloc);

  // Slot tracking: grants free slots, allocation wins over a same-slot grant.
  always_comb begin
    valid_d = valid_q;
    fu_d    = fu_q;
    older_d = older_q;
    if (flush) begin
      valid_d = '0;
    end else begin
      valid_d = (valid_q & ~grant_mask) | alloc_mask;
    end
    if (do_alloc) begin
      fu_d[alloc_idx] = alloc_fu;
      for (int j = 0; j < N_RS; j++) begin
        older_d[alloc_idx][j] = 1'b0;
      end
      for (int j = 0; j < N_RS; j++) begin
        older_d[j][alloc_idx] = valid_q[j] & ~alloc_mask[j];
      end
    end else begin
      fu_d    = fu_q;
      older_d = older_q;
    end
  end

  // Grant registers and multiplier occupancy counter.
  always_comb begin
    alu_valid_d  = gnt_alu & ~flush;
    mult_valid_d = gnt_mult & ~flush;
    mem_valid_d  = gnt_mem & ~flush;
    alu_idx_d    = alu_valid_d  ? sel_alu_idx  : '0;
    mult_idx_d   = mult_valid_d ? sel_mult_idx : '0;
    mem_idx_d    = mem_valid_d  ? sel_mem_idx  : '0;
    mult_cnt_d   = mult_cnt_q;
    if (mult_valid_d) begin
      mult_cnt_d = CNT_W'(MULT_LAT);
    end else if (mult_cnt_q != '0) begin
      mult_cnt_d = mult_cnt_q - CNT_W'(1);
    end else begin
      mult_cnt_d = mult_cnt_q;
    end
  end

  // State registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      valid_q      <= '0;
      older_q      <= '0;
      mult_cnt_q   <= '0;
      alu_valid_q  <= 1'b0;
      mult_valid_q <= 1'b0;
      mem_valid_q  <= 1'b0;
      alu_idx_q    <= '0;
      mult_idx_q   <= '0;
      mem_idx_q    <= '0;
      for (int i = 0; i < N_RS; i++) begin
        fu_q[i] <= FU_ALU;
      end
    end else begin
      valid_q      <= valid_d;
      older_q      <= older_d;
      mult_cnt_q   <= mult_cnt_d;
      alu_valid_q  <= alu_valid_d;
      mult_valid_q <= mult_valid_d;
      mem_valid_q  <= mem_valid_d;
      alu_idx_q    <= alu_idx_d;
      mult_idx_q   <= mult_idx_d;
      mem_idx_q    <= mem_idx_d;
      fu_q         <= fu_d;
    end
  end

  assign alu_issue_valid  = alu_valid_q;
  assign alu_issue_idx    = alu_idx_q;
  assign mult_issue_valid = mult_valid_q;
  assign mult_issue_idx   = mult_idx_q;
  assign mem_issue_valid  = mem_valid_q;
  assign mem_issue_idx    = mem_idx_q;
  assign issue_clear      = to_onehot(alu_idx_q, alu_valid_q)
                          | to_onehot(mult_idx_q, mult_valid_q)
                          | to_onehot(mem_idx_q, mem_valid_q);
  assign mult_busy        = (mult_cnt_q != '0);

endmodule

// File: tb/tb_issue_scheduler.sv
// Scoreboard bench for issue_scheduler: directed stimulus queues expected grants
// (unit, slot, cycle); a negedge monitor compares every cycle's grant outputs.
module tb_issue_scheduler;
  import sys_defs::*;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       alloc_valid = 1'b0;
  logic [2:0] alloc_idx = 3'd0;
  fu_type_e   alloc_fu = FU_ALU;
  logic [7:0] entry_ready = 8'h00;
  logic       mem_stall = 1'b0;
  logic       flush = 1'b0;
  logic       alu_issue_valid, mult_issue_valid, mem_issue_valid;
  logic [2:0] alu_issue_idx, mult_issue_idx, mem_issue_idx;
  logic [7:0] issue_clear;
  logic       mult_busy;

  issue_scheduler #(.N_RS(8), .IDX_W(3), .MULT_LAT(4)) dut (
    .clock(clock), .reset(reset),
    .alloc_valid(alloc_valid), .alloc_idx(alloc_idx), .alloc_fu(alloc_fu),
    .entry_ready(entry_ready), .mem_stall(mem_stall), .flush(flush),
    .alu_issue_valid(alu_issue_valid), .alu_issue_idx(alu_issue_idx),
    .mult_issue_valid(mult_issue_valid), .mult_issue_idx(mult_issue_idx),
    .mem_issue_valid(mem_issue_valid), .mem_issue_idx(mem_issue_idx),
    .issue_clear(issue_clear), .mult_busy(mult_busy)
  );

  always #5 clock = ~clock;

  typedef struct {
    int unit;
    int idx;
    int at;
  } exp_t;

  exp_t  exp_q[$];
  int    cyc = 0;
  int    checks = 0;
  int    errors = 0;
  bit    mon_en = 1'b0;
  string unames[3] = '{"alu", "mult", "mem"};

  always @(posedge clock) cyc <= cyc + 1;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0d, required %0d", name, cyc, act, exp);
    end
  endtask

  task automatic expect_grant(input int unit, input int idx, input int at);
    exp_t e;
    e.unit = unit;
    e.idx  = idx;
    e.at   = at;
    exp_q.push_back(e);
  endtask

  task automatic alloc(input int idx, input fu_type_e fu);
    alloc_valid = 1'b1;
    alloc_idx   = 3'(idx);
    alloc_fu    = fu;
    tick();
    alloc_valid = 1'b0;
  endtask

  // Monitor: every cycle, grant outputs must match exactly what was queued for that cycle.
  bit         ev[3];
  int         ei[3];
  bit         av[3];
  int         ai[3];
  logic [7:0] emask;
  always @(negedge clock) begin
    if (mon_en) begin
      for (int u = 0; u < 3; u++) begin
        ev[u] = 1'b0;
        ei[u] = 0;
      end
      while (exp_q.size() > 0 && exp_q[0].at <= cyc) begin
        if (exp_q[0].at < cyc) begin
          checks++;
          errors++;
          $display("FAIL missed_grant %s: got none by cycle %0d, required idx %0d at cycle %0d",
                   unames[exp_q[0].unit], cyc, exp_q[0].idx, exp_q[0].at);
        end else begin
          ev[exp_q[0].unit] = 1'b1;
          ei[exp_q[0].unit] = exp_q[0].idx;
        end
        void'(exp_q.pop_front());
      end
      av[0] = alu_issue_valid;  ai[0] = int'(alu_issue_idx);
      av[1] = mult_issue_valid; ai[1] = int'(mult_issue_idx);
      av[2] = mem_issue_valid;  ai[2] = int'(mem_issue_idx);
      emask = 8'h00;
      for (int u = 0; u < 3; u++) begin
        checks++;
        if (av[u] != ev[u]) begin
          errors++;
          $display("FAIL %s_valid at cycle %0d: got %0d, required %0d", unames[u], cyc, av[u], ev[u]);
        end else if (ev[u]) begin
          checks++;
          if (ai[u] != ei[u]) begin
            errors++;
            $display("FAIL %s_idx at cycle %0d: got %0d, required %0d", unames[u], cyc, ai[u], ei[u]);
          end
        end
        if (ev[u]) emask[ei[u]] = 1'b1;
      end
      checks++;
      if (issue_clear !== emask) begin
        errors++;
        $display("FAIL issue_clear at cycle %0d: got %h, required %h", cyc, issue_clear, emask);
      end
    end
  end

  int k;
  initial begin
    // Reset state
    tick();
    tick();
    chk("rst_alu_valid", alu_issue_valid, 0);
    chk("rst_mult_valid", mult_issue_valid, 0);
    chk("rst_mem_valid", mem_issue_valid, 0);
    chk("rst_idx_or", alu_issue_idx | mult_issue_idx | mem_issue_idx, 0);
    chk("rst_issue_clear", issue_clear, 0);
    chk("rst_mult_busy", mult_busy, 0);
    reset  = 1'b0;
    mon_en = 1'b1;
    tick();

    // Single ALU alloc with ready: grant two cycles after the alloc edge
    entry_ready = 8'h08;
    alloc_valid = 1'b1; alloc_idx = 3'd3; alloc_fu = FU_ALU;
    k = cyc;
    expect_grant(0, 3, k + 2);
    tick();
    alloc_valid = 1'b0;
    repeat (3) tick();
    entry_ready = 8'h00;
    tick();

    // Age order 5, 2, 7
    alloc(5, FU_ALU);
    alloc(2, FU_ALU);
    alloc(7, FU_ALU);
    entry_ready = 8'hA4;
    k = cyc;
    expect_grant(0, 5, k + 1);
    expect_grant(0, 2, k + 2);
    expect_grant(0, 7, k + 3);
    repeat (5) tick();
    entry_ready = 8'h00;

    // Multiplier spacing
    alloc(1, FU_MULT);
    alloc(4, FU_MULT);
    entry_ready = 8'h12;
    k = cyc;
    expect_grant(1, 1, k + 1);
    expect_grant(1, 4, k + 5);
    chk("mult_busy_idle", mult_busy, 0);
    for (int i = 1; i <= 4; i++) begin
      tick();
      chk("mult_busy_run", mult_busy, 1);
    end
    tick();
    chk("mult_busy_reload", mult_busy, 1);
    entry_ready = 8'h00;
    repeat (3) tick();
    tick();
    chk("mult_busy_done", mult_busy, 0);

    // All three units in one cycle
    alloc(0, FU_ALU);
    alloc(2, FU_MULT);
    alloc(6, FU_MEM);
    entry_ready = 8'h45;
    k = cyc;
    expect_grant(0, 0, k + 1);
    expect_grant(1, 2, k + 1);
    expect_grant(2, 6, k + 1);
    repeat (6) tick();
    entry_ready = 8'h00;

    // MEM withheld while stalled
    alloc(1, FU_ALU);
    alloc(3, FU_MULT);
    alloc(5, FU_MEM);
    mem_stall   = 1'b1;
    entry_ready = 8'h2A;
    k = cyc;
    expect_grant(0, 1, k + 1);
    expect_grant(1, 3, k + 1);
    expect_grant(2, 5, k + 4);
    repeat (3) tick();
    mem_stall = 1'b0;
    repeat (4) tick();
    entry_ready = 8'h00;

    // Flush with alloc: nothing issues, multiplier keeps counting
    alloc(0, FU_ALU);
    alloc(1, FU_ALU);
    alloc(2, FU_MEM);
    alloc(3, FU_MULT);
    alloc(4, FU_ALU);
    entry_ready = 8'h08;
    k = cyc;
    expect_grant(1, 3, k + 1);
    tick();
    entry_ready = 8'h37;
    flush       = 1'b1;
    alloc_valid = 1'b1; alloc_idx = 3'd5; alloc_fu = FU_ALU;
    chk("flush_busy_k1", mult_busy, 1);
    tick();
    flush       = 1'b0;
    alloc_valid = 1'b0;
    chk("flush_busy_k2", mult_busy, 1);
    tick();
    chk("flush_busy_k3", mult_busy, 1);
    tick();
    chk("flush_busy_k4", mult_busy, 1);
    tick();
    chk("flush_busy_k5", mult_busy, 0);
    repeat (2) tick();
    entry_ready = 8'h00;

    // Overwrite in grant cycle: alloc wins and slot 6 becomes youngest MEM
    alloc(6, FU_ALU);
    alloc(1, FU_MEM);
    entry_ready = 8'h40;
    alloc_valid = 1'b1; alloc_idx = 3'd6; alloc_fu = FU_MEM;
    k = cyc;
    expect_grant(0, 6, k + 1);
    tick();
    alloc_valid = 1'b0;
    entry_ready = 8'h42;
    expect_grant(2, 1, k + 2);
    expect_grant(2, 6, k + 3);
    repeat (5) tick();
    entry_ready = 8'h00;

    // Reset mid-operation clears the multiplier counter at once
    alloc(0, FU_MULT);
    entry_ready = 8'h01;
    k = cyc;
    expect_grant(1, 0, k + 1);
    tick();
    entry_ready = 8'h00;
    tick();
    chk("pre_reset_busy", mult_busy, 1);
    reset = 1'b1;
    #1;
    chk("mid_reset_busy", mult_busy, 0);
    chk("mid_reset_clear", issue_clear, 0);
    tick();
    reset = 1'b0;
    repeat (3) tick();

    chk("queue_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/issue_scheduler.md
Name: issue_scheduler

Overview:
- Issue-select controller for the reservation station (RS) in the R10K-style out-of-order core.
- Tracks which RS slots hold a dispatched instruction, their FU class and relative age.
- Each cycle, grants at most one ready slot per functional unit (ALU, MULT, MEM), oldest first.
- Sequences the unpipelined multiplier with a busy counter and frees granted RS slots.

Parameters:
N_RS, 8, number of RS slots tracked (power of two, >=2)
IDX_W, $clog2(N_RS), slot index width
MULT_LAT, 4, multiplier occupancy in cycles (>=1)

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
alloc_valid  in  1  dispatch writes an instruction into RS slot alloc_idx this cycle
alloc_idx  in  IDX_W  slot being allocated
alloc_fu  in  FU_TYPE(2)  FU class of allocated instruction (FU_ALU/FU_MULT/FU_MEM)
entry_ready  in  N_RS  per-slot "both source tags ready" from RS
mem_stall  in  1  MEM unit cannot accept an issue this cycle
flush  in  1  branch mispredict squash; drop all tracked slots
alu_issue_valid / alu_issue_idx  out  1 / IDX_W  registered ALU grant
mult_issue_valid / mult_issue_idx  out  1 / IDX_W  registered MULT grant
mem_issue_valid / mem_issue_idx  out  1 / IDX_W  registered MEM grant
issue_clear  out  N_RS  one-hot OR of current grants; RS frees these slots
mult_busy  out  1  multiplier occupied

Behaviour:
- State: valid[N_RS], fu[N_RS], age matrix older[i][j] (i older than j), mult_cnt (width $clog2(MULT_LAT+1)), registered grant outputs.
- Reset (async): valid=0, older=0, mult_cnt=0, all *_issue_valid=0, *_issue_idx=0, issue_clear=0, mult_busy=0.
- Allocation (edge): valid[a]=1, fu[a]=alloc_fu, older[j][a]=valid[j] for all j!=a, older[a][*]=0. Allocating a valid slot overwrites it and makes it youngest.
- Eligible(i,class) = valid[i] & entry_ready[i] & fu[i]==class. A slot allocated this cycle is not eligible until the next cycle.
- Select (comb): per class, the eligible slot with no eligible older slot of the same class. If no slot qualifies, there is no grant.
- MULT is gated by mult_cnt<=1. MEM is gated by !mem_stall. ALU is never gated.
- Latency: a selection in cycle t appears on *_issue_valid/idx in cycle t+1. valid[i] clears at the same edge, so the slot cannot be reselected.
- issue_clear is decoded combinationally from the registered grants and is asserted in cycle t+1.
- Multiplier: the edge registering a MULT grant loads mult_cnt=MULT_LAT. Otherwise mult_cnt decrements when nonzero. mult_busy = mult_cnt!=0. Back-to-back MULT grants are spaced exactly MULT_LAT cycles apart.
- Flush (edge): valid=0 and all issue_valid=0 at the next edge. Alloc and selection in the flush cycle are discarded. mult_cnt keeps counting, since an in-flight multiply still occupies the unit.
- Simultaneous alloc to slot a and grant of slot a (only possible on overwrite): the alloc wins and valid[a] stays 1.
- Same-age ties are impossible by construction, and the age matrix is never consulted for invalid slots.
- Reset mid-operation clears everything immediately, including mult_cnt.

Decomposition:
- Shared package (sys_defs): FU_TYPE enum {FU_ALU=2'd0, FU_MULT=2'd1, FU_MEM=2'd2}, N_RS default, MULT_LAT default.
- One sub-module, age_select: parameter N. Inputs: eligible vector and age matrix. Outputs: grant valid plus index of the oldest eligible slot. Instantiated three times.

Test Plan:
- Reset, then alloc slot 3 ALU, entry_ready[3]=1 -> next cycle alu_issue_valid=1, alu_issue_idx=3, issue_clear=8'h08; following cycle no grant.
- Alloc ALU slots 5, 2, 7 in order; raise entry_ready for all three together -> ALU grants idx 5, 2, 7 on three consecutive cycles.
- MULT_LAT=4, MULT slots 1 and 4 ready together -> grant 1 at cycle t+1, mult_busy high 4 cycles, grant 4 exactly at t+5.
- One ALU, one MULT and one MEM slot ready together -> all three issue_valid in the same cycle, issue_clear has 3 bits set. With mem_stall=1, MEM is withheld until stall drops.
- Four slots valid and ready, flush asserted with alloc_valid=1 -> next cycle no grants, no valid slots; mult_cnt continues its countdown.
- Overwrite alloc to ready slot 6 in its grant cycle -> grant idx 6 emitted, valid[6] remains set with the new FU class and youngest age.
